zstd_header_writer: RTL and testbench

ZSTD_HEADER_WRITER -- requirements
Module: zstd_header_writer

---
 rtl/zstd_pkg.sv | 28 ++
 rtl/zstd_hdr_size_calc.sv | 71 +++++++
 rtl/zstd_header_writer.sv | 150 +++++++++++++++
 tb/tb_zstd_header_writer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zstd_pkg.sv
// Shared Zstandard frame-header definitions: magic, buffer size, writer states, flag types.
package zstd_pkg;

  localparam logic [31:0]  ZSTD_MAGIC         = 32'hFD2FB528;
  localparam int unsigned  ZSTD_HDR_MAX_BYTES = 18;
  localparam int unsigned  ZSTD_DID_W         = 32;
  localparam int unsigned  ZSTD_FCS_W         = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } writer_state_e;

  typedef logic [1:0] fcs_flag_t;
  typedef logic [1:0] did_flag_t;

  // Frame configuration captured on an accepted start
  typedef struct packed {
    logic                  single_segment;
    logic                  content_checksum;
    logic                  fcs_valid;
    logic [7:0]            window_descriptor;
    logic [ZSTD_DID_W-1:0] dictionary_id;
    logic [ZSTD_FCS_W-1:0] frame_content_size;
  } hdr_cfg_t;

endpackage

// File: rtl/zstd_hdr_size_calc.sv
// Combinational FCS/DID flag selection and header byte count.
// Dictionary ID encoding is present only when ZSTD_HDR_DID_EN is defined.
module zstd_hdr_size_calc
  import zstd_pkg::*;
(
  input  logic        single_segment,
  input  logic        fcs_valid,
  input  logic [31:0] dictionary_id,
  input  logic [63:0] frame_content_size,
  output logic [1:0]  fcs_flag_c,
  output logic [3:0]  fcs_nbytes_c,
  output logic [1:0]  did_flag_c,
  output logic [2:0]  did_nbytes_c,
  output logic [4:0]  header_len_c
);

  fcs_flag_t fcs_flag;
  did_flag_t did_flag;

  // Smallest FCS field; single-segment frames may use the 1-byte form
  always_comb begin
    fcs_flag     = 2'd0;
    fcs_nbytes_c = 4'd0;
    if (fcs_valid) begin
      if (frame_content_size < 64'd256) begin
        fcs_flag     = single_segment ? 2'd0 : 2'd2;
        fcs_nbytes_c = single_segment ? 4'd1 : 4'd4;
      end else if (frame_content_size < 64'd65792) begin
        fcs_flag     = 2'd1;
        fcs_nbytes_c = 4'd2;
      end else if (frame_content_size[63:32] == 32'd0) begin
        fcs_flag     = 2'd2;
        fcs_nbytes_c = 4'd4;
      end else begin
        fcs_flag     = 2'd3;
        fcs_nbytes_c = 4'd8;
      end
    end
  end

`ifdef ZSTD_HDR_DID_EN
  always_comb begin
    did_flag     = 2'd0;
    did_nbytes_c = 3'd0;
    if (dictionary_id == 32'd0) begin
      did_flag     = 2'd0;
      did_nbytes_c = 3'd0;
    end else if (dictionary_id[31:8] == 24'd0) begin
      did_flag     = 2'd1;
      did_nbytes_c = 3'd1;
    end else if (dictionary_id[31:16] == 16'd0) begin
      did_flag     = 2'd2;
      did_nbytes_c = 3'd2;
    end else begin
      did_flag     = 2'd3;
      did_nbytes_c = 3'd4;
    end
  end
`else
  logic unused_did;
  assign unused_did   = ^dictionary_id;
  assign did_flag     = 2'd0;
  assign did_nbytes_c = 3'd0;
`endif

  assign fcs_flag_c   = fcs_flag;
  assign did_flag_c   = did_flag;
  assign header_len_c = 5'd5 + {4'd0, ~single_segment} + {2'd0, did_nbytes_c}
                        + {1'b0, fcs_nbytes_c};

endmodule

// File: rtl/zstd_header_writer.sv
// Zstandard frame header serializer: builds the header in one cycle, streams it 2 bytes per beat.
// Define ZSTD_HDR_DID_EN to include the dictionary ID field.
module zstd_header_writer
  import zstd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        single_segment,
  input  logic        content_checksum,
  input  logic        fcs_valid,
  input  logic [7:0]  window_descriptor,
  input  logic [31:0] dictionary_id,
  input  logic [63:0] frame_content_size,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_nbytes,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  header_len
);

  localparam int unsigned HDR_W = 8 * ZSTD_HDR_MAX_BYTES;

  writer_state_e    state;
  hdr_cfg_t         cfg_q;
  logic [HDR_W-1:0] buf_q;
  logic [4:0]       remaining;

  logic [1:0]       fcs_flag_c;
  logic [3:0]       fcs_nbytes_c;
  logic [1:0]       did_flag_c;
  logic [2:0]       did_nbytes_c;
  logic [4:0]       header_len_c;
  logic [7:0]       fhd_c;
  logic [31:0]      did_val_c;
  logic [63:0]      fcs_val_c;
  logic [4:0]       off_c;
  logic [HDR_W-1:0] hdr_c;
  logic [4:0]       rem_next_c;

  zstd_hdr_size_calc u_size_calc (
    .single_segment     (cfg_q.single_segment),
    .fcs_valid          (cfg_q.fcs_valid),
    .dictionary_id      (cfg_q.dictionary_id),
    .frame_content_size (cfg_q.frame_content_size),
    .fcs_flag_c         (fcs_flag_c),
    .fcs_nbytes_c       (fcs_nbytes_c),
    .did_flag_c         (did_flag_c),
    .did_nbytes_c       (did_nbytes_c),
    .header_len_c       (header_len_c)
  );

  assign fhd_c = {fcs_flag_c, cfg_q.single_segment, 1'b0, 1'b0,
                  cfg_q.content_checksum, did_flag_c};

  // Minimal flags guarantee each value fits its field, so only absent fields need zeroing
  assign did_val_c = (did_nbytes_c == 3'd0) ? 32'd0 : cfg_q.dictionary_id;
  assign fcs_val_c = (fcs_nbytes_c == 4'd0) ? 64'd0 :
                     (fcs_flag_c == 2'd1)   ? cfg_q.frame_content_size - 64'd256 :
                                              cfg_q.frame_content_size;

  // Little-endian byte image: byte k of the stream sits at hdr_c[8k +: 8]
  always_comb begin
    hdr_c = HDR_W'(ZSTD_MAGIC);
    hdr_c = hdr_c | (HDR_W'(fhd_c) << 32);
    off_c = 5'd5;
    if (!cfg_q.single_segment) begin
      hdr_c = hdr_c | (HDR_W'(cfg_q.window_descriptor) << 40);
      off_c = 5'd6;
    end
    hdr_c = hdr_c | (HDR_W'(did_val_c) << {off_c, 3'b000});
    off_c = off_c + {2'd0, did_nbytes_c};
    hdr_c = hdr_c | (HDR_W'(fcs_val_c) << {off_c, 3'b000});
  end

  assign rem_next_c = remaining - 5'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cfg_q      <= '0;
      buf_q      <= '0;
      remaining  <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_nbytes <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      header_len <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (single_segment && !fcs_valid) begin
              error <= 1'b1;
            end else begin
              cfg_q <= '{single_segment:     single_segment,
                         content_checksum:   content_checksum,
                         fcs_valid:          fcs_valid,
                         window_descriptor:  window_descriptor,
                         dictionary_id:      dictionary_id,
                         frame_content_size: frame_content_size};
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          buf_q      <= hdr_c;
          remaining  <= header_len_c;
          header_len <= header_len_c;
          out_data   <= {hdr_c[7:0], hdr_c[15:8]};
          out_nbytes <= 2'd2;
          out_last   <= 1'b0;
          out_valid  <= 1'b1;
          state      <= EMIT;
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_data   <= '0;
              out_nbytes <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end else begin
              buf_q      <= buf_q >> 16;
              remaining  <= rem_next_c;
              out_data   <= {buf_q[23:16], buf_q[31:24]};
              out_nbytes <= (rem_next_c >= 5'd2) ? 2'd2 : 2'd1;
              out_last   <= (rem_next_c <= 5'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zstd_header_writer.sv
// Self-checking bench for zstd_header_writer: directed vectors, boundaries, stalls, reset, error.
module tb_zstd_header_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        single_segment = 1'b0;
  logic        content_checksum = 1'b0;
  logic        fcs_valid = 1'b0;
  logic [7:0]  window_descriptor = '0;
  logic [31:0] dictionary_id = '0;
  logic [63:0] frame_content_size = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_nbytes;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  header_len;

  zstd_header_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .single_segment     (single_segment),
    .content_checksum   (content_checksum),
    .fcs_valid          (fcs_valid),
    .window_descriptor  (window_descriptor),
    .dictionary_id      (dictionary_id),
    .frame_content_size (frame_content_size),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_nbytes         (out_nbytes),
    .out_last           (out_last),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .header_len         (header_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  nb;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [15:0] d, input logic [1:0] nb, input logic last);
    beat_t e;
    e.data = d;
    e.nb   = nb;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Reference model: assemble the byte stream field by field, then pair into beats
  task automatic model_push(output int len);
    logic [7:0]  b[$];
    int          dn;
    int          fn;
    logic [1:0]  df;
    logic [1:0]  ff;
    logic [63:0] fval;
    b = {8'h28, 8'hB5, 8'h2F, 8'hFD};
`ifdef ZSTD_HDR_DID_EN
    if (dictionary_id == 0)               begin dn = 0; df = 2'd0; end
    else if (dictionary_id < 32'h100)     begin dn = 1; df = 2'd1; end
    else if (dictionary_id < 32'h10000)   begin dn = 2; df = 2'd2; end
    else                                  begin dn = 4; df = 2'd3; end
`else
    dn = 0;
    df = 2'd0;
`endif
    if (!fcs_valid)                             begin fn = 0; ff = 2'd0; end
    else if (frame_content_size < 64'd256)      begin fn = single_segment ? 1 : 4;
                                                      ff = single_segment ? 2'd0 : 2'd2; end
    else if (frame_content_size < 64'd65792)    begin fn = 2; ff = 2'd1; end
    else if (frame_content_size <= 64'hFFFF_FFFF) begin fn = 4; ff = 2'd2; end
    else                                        begin fn = 8; ff = 2'd3; end
    fval = (ff == 2'd1) ? frame_content_size - 64'd256 : frame_content_size;
    b.push_back({ff, single_segment, 1'b0, 1'b0, content_checksum, df});
    if (!single_segment) b.push_back(window_descriptor);
    for (int i = 0; i < dn; i++) b.push_back(dictionary_id[8*i +: 8]);
    for (int i = 0; i < fn; i++) b.push_back(fval[8*i +: 8]);
    len = b.size();
    for (int i = 0; i < len; i += 2) begin
      push_beat({b[i], (i + 1 < len) ? b[i+1] : 8'h00},
                (i + 1 < len) ? 2'd2 : 2'd1, (i + 2 >= len));
    end
  endtask

  task automatic set_cfg(input logic ss, input logic ck, input logic fv, input logic [7:0] wd,
                         input logic [31:0] did, input logic [63:0] fcs);
    single_segment     = ss;
    content_checksum   = ck;
    fcs_valid          = fv;
    window_descriptor  = wd;
    dictionary_id      = did;
    frame_content_size = fcs;
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks hold during stalls
  logic [15:0] held_data;
  logic [1:0]  held_nb;
  logic        held_last;
  bit          stalled = 1'b0;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (stalled) begin
        check("hold_data", out_data, held_data);
        check("hold_nbytes", out_nbytes, held_nb);
        check("hold_last", out_last, held_last);
      end
      if (out_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed %04h with empty scoreboard, expected no beat",
                 out_data);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_nbytes", out_nbytes, e.nb);
          check("beat_last", out_last, e.last);
        end
      end
      held_data = out_data;
      held_nb   = out_nbytes;
      held_last = out_last;
      stalled   = !out_ready;
    end else begin
      stalled = 1'b0;
    end
  end

  // Start a header (called just after a clock edge) and wait for done
  task automatic run_header(input int exp_len, input bit stall, input bit rand_rdy);
    bit got_done;
    got_done = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_no_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("first_valid", out_valid, 1'b1);
    if (stall) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      set_cfg(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 64'h0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_ignored_err", error, 1'b0);
      check("stall_beat2", out_data, 16'h2FFD);
      @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    check("done_seen", got_done, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("header_len", header_len, 5'(exp_len));
    check("idle_busy", busy, 1'b0);
    check("idle_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("done_pulse", done, 1'b0);
    check("header_len_hold", header_len, 5'(exp_len));
  endtask

  task automatic run_model(input bit rand_rdy);
    int len;
    model_push(len);
    run_header(len, 1'b0, rand_rdy);
  endtask

  initial begin
    int len;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data, 16'h0);
    check("rst_nbytes", out_nbytes, 2'd0);
    check("rst_hlen", header_len, 5'd0);
    check("rst_done", {done, error, out_last}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single segment, 1-byte FCS
    set_cfg(1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 64'h10);
    push_beat(16'h28B5, 2'd2, 1'b0);
    push_beat(16'h2FFD, 2'd2, 1'b0);
    push_beat(16'h2010, 2'd2, 1'b1);
    run_header(6, 1'b0, 1'b0);

    // Window descriptor only
    set_cfg(1'b0, 1'b0, 1'b0, 8'h58, 32'h0, 64'h0);
    push_beat(16'h28B5, 2'd2, 1'b0);
    push_beat(16'h2FFD, 2'd2, 1'b0);
    push_beat(16'h0058, 2'd2, 1'b1);
    run_header(6, 1'b0, 1'b0);

    // 2-byte FCS with offset, checksum flag, small dictionary
    set_cfg(1'b1, 1'b1, 1'b1, 8'h00, 32'h05, 64'h1234);
    push_beat(16'h28B5, 2'd2, 1'b0);
    push_beat(16'h2FFD, 2'd2, 1'b0);
`ifdef ZSTD_HDR_DID_EN
    push_beat(16'h6505, 2'd2, 1'b0);
    push_beat(16'h3411, 2'd2, 1'b1);
    run_header(8, 1'b0, 1'b0);
`else
    push_beat(16'h6434, 2'd2, 1'b0);
    push_beat(16'h1100, 2'd1, 1'b1);
    run_header(7, 1'b0, 1'b0);
`endif

    // Odd length tail
    set_cfg(1'b0, 1'b0, 1'b0, 8'h40, 32'hAB, 64'h0);
    push_beat(16'h28B5, 2'd2, 1'b0);
    push_beat(16'h2FFD, 2'd2, 1'b0);
`ifdef ZSTD_HDR_DID_EN
    push_beat(16'h0140, 2'd2, 1'b0);
    push_beat(16'hAB00, 2'd1, 1'b1);
    run_header(7, 1'b0, 1'b0);
`else
    push_beat(16'h0040, 2'd2, 1'b1);
    run_header(6, 1'b0, 1'b0);
`endif

    // Back-pressure on beat 2 with an ignored start; largest header
    set_cfg(1'b0, 1'b1, 1'b1, 8'h77, 32'h12345, 64'h1_2345_6789);
    model_push(len);
    run_header(len, 1'b1, 1'b0);

    // FCS and DID size boundaries
    set_cfg(1'b0, 1'b0, 1'b1, 8'h01, 32'hFF,    64'd255);        run_model(1'b0);
    set_cfg(1'b1, 1'b0, 1'b1, 8'h00, 32'h100,   64'd256);        run_model(1'b0);
    set_cfg(1'b1, 1'b1, 1'b1, 8'h00, 32'hFFFF,  64'd65791);      run_model(1'b0);
    set_cfg(1'b0, 1'b0, 1'b1, 8'h22, 32'h10000, 64'd65792);      run_model(1'b0);
    set_cfg(1'b1, 1'b0, 1'b1, 8'h00, 32'h0,     64'hFFFF_FFFF);  run_model(1'b0);
    set_cfg(1'b1, 1'b0, 1'b1, 8'h00, 32'h0,     64'h1_0000_0000); run_model(1'b0);

    // Random configurations with random back-pressure
    for (int i = 0; i < 6; i++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              8'($urandom), $urandom >> $urandom_range(0, 31),
              {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63));
      run_model(1'b1);
    end

    // Single segment without content size is rejected
    set_cfg(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 64'h0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", error, 1'b1);
    check("err_busy", busy, 1'b0);
    check("err_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("err_pulse_end", error, 1'b0);
    check("err_valid2", out_valid, 1'b0);

    // Reset while beat 2 is presented
    set_cfg(1'b0, 1'b0, 1'b1, 8'h10, 32'h3, 64'd1000);
    model_push(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_beat2", out_data, 16'h2FFD);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", out_data, 16'h0);
    check("mid_rst_hlen", header_len, 5'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    set_cfg(1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 64'h10);
    model_push(len);
    run_header(len, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
